// File: rtl/modulo_mux16_1_serializer.sv
// modulo_mux16_1_serializer: sequential 16:1 mux that serializes a captured word onto Y, one slot per DIV cycles
// Ports:
//   CLK    - clock, rising edge
//   RST_N  - asynchronous active-low reset
//   D      - 16-bit parallel word, captured at frame start (and at each loop wrap)
//   START  - frame request, honoured only in IDLE
//   LOOP   - continuous mode, read at the slot-15 boundary
//   S      - slot select for the far-end demux
//   Y      - serial data, shadow[S]
//   VALID  - S/Y carry a live slot
//   BUSY   - frame in progress, through the DONE cycle
//   DONE   - one-cycle end-of-frame pulse (non-looping frames only)
module modulo_mux16_1_serializer #(
    parameter int DIV = 1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [15:0] D,
    input  logic        START,
    input  logic        LOOP,
    output logic [3:0]  S,
    output logic        Y,
    output logic        VALID,
    output logic        BUSY,
    output logic        DONE
);
    localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DONE} state_t;
    state_t         state, state_n;
    logic [15:0]    shadow, shadow_n;
    logic [3:0]     slot, slot_n;
    logic [PW-1:0]  pre, pre_n;
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state  <= ST_IDLE;
            shadow <= '0;
            slot   <= '0;
            pre    <= '0;
        end else begin
            state  <= state_n;
            shadow <= shadow_n;
            slot   <= slot_n;
            pre    <= pre_n;
        end
    end
    always_comb begin
        state_n  = state;
        shadow_n = shadow;
        slot_n   = slot;
        pre_n    = pre;
        unique case (state)
            ST_IDLE: begin
                if (START) begin
                    shadow_n = D;
                    slot_n   = '0;
                    pre_n    = '0;
                    state_n  = ST_SCAN;
                end
            end
            ST_SCAN: begin
                pre_n = pre == PRE_MAX ? '0 : pre + PW'(1);
                if (pre == PRE_MAX) begin
                    if (slot != 4'd15) begin
                        slot_n = slot + 4'd1;
                    end else if (LOOP) begin
                        // wrap straight into the next frame with a fresh capture, no gap
                        shadow_n = D;
                        slot_n   = '0;
                    end else begin
                        slot_n  = '0;
                        state_n = ST_DONE;
                    end
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end
    // outputs are a registered decode of the current state, so they trail the state by one cycle
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            S     <= '0;
            Y     <= 1'b0;
            VALID <= 1'b0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
        end else begin
            S     <= state == ST_SCAN ? slot : 4'd0;
            Y     <= state == ST_SCAN && shadow[slot];
            VALID <= state == ST_SCAN;
            BUSY  <= state != ST_IDLE;
            DONE  <= state == ST_DONE;
        end
    end
endmodule

// File: tb/tb_modulo_mux16_1_serializer.sv
// tb_modulo_mux16_1_serializer: scoreboard bench for DIV=1 and DIV=3 serializer instances
module tb_modulo_mux16_1_serializer;
    typedef struct packed {
        logic [3:0] s;
        logic       y;
        logic       valid;
        logic       busy;
        logic       done;
    } out_t;
    typedef struct {
        int          sel;
        logic [15:0] d;
        logic [15:0] y;
    } vec_t;
    localparam out_t IDLE_O = '0;
    localparam out_t DONE_O = '{s: 4'd0, y: 1'b0, valid: 1'b0, busy: 1'b1, done: 1'b1};
    localparam int DIVS [2] = '{1, 3};
    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       start, loop_m, y, valid, busy, done;
    logic [1:0][15:0] d;
    logic [1:0][3:0]  s;
    out_t             q [2][$];
    bit               chk_en = 1'b0;
    int               pass_cnt = 0;
    int               total = 0;
    vec_t             tbl [6];
    always #5 clk = ~clk;
    modulo_mux16_1_serializer #(.DIV(1)) u_div1 (
        .CLK(clk), .RST_N(rst_n), .D(d[0]), .START(start[0]), .LOOP(loop_m[0]),
        .S(s[0]), .Y(y[0]), .VALID(valid[0]), .BUSY(busy[0]), .DONE(done[0])
    );
    modulo_mux16_1_serializer #(.DIV(3)) u_div3 (
        .CLK(clk), .RST_N(rst_n), .D(d[1]), .START(start[1]), .LOOP(loop_m[1]),
        .S(s[1]), .Y(y[1]), .VALID(valid[1]), .BUSY(busy[1]), .DONE(done[1])
    );
    function automatic out_t act(int i);
        return {s[i], y[i], valid[i], busy[i], done[i]};
    endfunction
    task automatic chk(string nm, out_t a, out_t e);
        total++;
        if (a === e) pass_cnt++;
        else $display("FAIL %s t=%0t actual{s,y,v,b,d}=%h required=%h", nm, $time, a, e);
    endtask
    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask
    // expected output stream of one frame: optional idle latency, DIV records per slot, optional DONE
    task automatic push_frame(int i, logic [15:0] ybits, int lead, bit last);
        for (int k = 0; k < lead; k++) q[i].push_back(IDLE_O);
        for (int sl = 0; sl < 16; sl++)
            for (int c = 0; c < DIVS[i]; c++)
                q[i].push_back({4'(sl), ybits[sl], 1'b1, 1'b1, 1'b0});
        if (last) q[i].push_back(DONE_O);
    endtask
    task automatic drain();
        int n = 0;
        while ((q[0].size() != 0 || q[1].size() != 0) && n < 200) begin
            tick(1);
            n++;
        end
        if (n >= 200) begin
            total++;
            $display("FAIL drain_timeout actual=%0d/%0d required=0/0", q[0].size(), q[1].size());
        end
    endtask
    // an empty queue means the instance must be idle
    always @(negedge clk) begin
        out_t e;
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                e = q[i].size() != 0 ? q[i].pop_front() : IDLE_O;
                chk(i == 0 ? "div1_out" : "div3_out", act(i), e);
            end
        end
    end
    initial begin
        tbl[0] = '{0, 16'hA5C3, 16'hA5C3};
        tbl[1] = '{1, 16'h8001, 16'h8001};
        tbl[2] = '{0, 16'h0000, 16'h0000};
        tbl[3] = '{0, 16'hFFFF, 16'hFFFF};
        tbl[4] = '{1, 16'h5A5A, 16'h5A5A};
        tbl[5] = '{0, 16'h1234, 16'h1234};
        start = '0;
        loop_m = '0;
        d = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_div1", act(0), IDLE_O);
        chk("reset_div3", act(1), IDLE_O);
        @(posedge clk);
        tick(1);
        rst_n = 1'b1;
        chk_en = 1'b1;
        tick(2);
        for (int v = 0; v < 6; v++) begin
            d[tbl[v].sel] = tbl[v].d;
            start[tbl[v].sel] = 1'b1;
            push_frame(tbl[v].sel, tbl[v].y, 2, 1'b1);
            tick(1);
            start[tbl[v].sel] = 1'b0;
            d[tbl[v].sel] = ~tbl[v].d;
            drain();
            tick(2);
        end
        // looping: FFFF, then 0000, then 1234 closed by a single DONE
        loop_m[0] = 1'b1;
        d[0] = 16'hFFFF;
        start[0] = 1'b1;
        push_frame(0, 16'hFFFF, 2, 1'b0);
        push_frame(0, 16'h0000, 0, 1'b0);
        push_frame(0, 16'h1234, 0, 1'b1);
        tick(1);
        start[0] = 1'b0;
        d[0] = 16'h0000;
        tick(16);
        d[0] = 16'h1234;
        tick(16);
        loop_m[0] = 1'b0;
        d[0] = 16'hBEEF;
        drain();
        tick(3);
        // START held high: new frame every 18 cycles, D recaptured
        d[0] = 16'h0F0F;
        start[0] = 1'b1;
        push_frame(0, 16'h0F0F, 2, 1'b1);
        push_frame(0, 16'hC0DE, 1, 1'b1);
        tick(1);
        d[0] = 16'hC0DE;
        tick(18);
        start[0] = 1'b0;
        d[0] = 16'h0000;
        drain();
        tick(3);
        // D toggled and START re-pulsed mid-frame are ignored
        d[0] = 16'h3C96;
        start[0] = 1'b1;
        push_frame(0, 16'h3C96, 2, 1'b1);
        tick(1);
        start[0] = 1'b0;
        tick(4);
        d[0] = ~16'h3C96;
        start[0] = 1'b1;
        tick(1);
        start[0] = 1'b0;
        drain();
        tick(4);
        // reset while slot 7 is on the line
        d[0] = 16'hFFFF;
        start[0] = 1'b1;
        push_frame(0, 16'hFFFF, 2, 1'b1);
        tick(1);
        start[0] = 1'b0;
        tick(8);
        chk("pre_reset_slot7", act(0), {4'd7, 1'b1, 1'b1, 1'b1, 1'b0});
        rst_n = 1'b0;
        q[0].delete();
        #1;
        chk("async_reset", act(0), IDLE_O);
        tick(2);
        rst_n = 1'b1;
        d[0] = 16'h00F0;
        start[0] = 1'b1;
        push_frame(0, 16'h00F0, 2, 1'b1);
        tick(1);
        start[0] = 1'b0;
        drain();
        tick(3);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/modulo_mux16_1_serializer.md
# modulo_mux16_1_serializer

Sequential 16:1 multiplexer that serializes a 16-bit word onto one line, one bit per slot. It generates the 4-bit slot select `S` that drives the far-end 1:16 demultiplexer. The pair moves a 16-bit parallel bus across one data line plus four select lines. The block captures the word, scans slots 0..15, and reports frame completion.

## Interface
Parameters:
- `DIV`, default 1: clock cycles per slot; legal range 1..256.

Ports:
- `CLK`  input  1: single clock; all state changes on the rising edge.
- `RST_N`  input  1: asynchronous, active-low reset.
- `D`  input  16: parallel word to serialize; sampled only at frame capture.
- `START`  input  1: request a frame; honoured only in IDLE.
- `LOOP`  input  1: continuous mode; sampled at the end of each frame.
- `S`  output  4: current slot select, to the demux select inputs.
- `Y`  output  1: serial data equal to `shadow[S]`, to the demux `E` input.
- `VALID`  output  1: high while `S`/`Y` carry a live slot.
- `BUSY`  output  1: high from the frame start through the DONE cycle.
- `DONE`  output  1: one-cycle pulse after the last slot of a non-looping frame.

## Operation
- Internal state:
  - `shadow[15:0]`: captured word.
  - `slot[3:0]`: current slot number.
  - `pre`: prescaler, counts 0..DIV-1, width ceil(log2(DIV)) with a minimum of 1.
  - FSM with states IDLE, SCAN and DONE.
- All outputs are registered. There is no combinational path from an input to an output.
- Outputs in IDLE:
  - S=0, Y=0, VALID=0, BUSY=0, DONE=0.
- IDLE to SCAN:
  - IDLE with START=1: shadow<=D, slot<=0, pre<=0, next state SCAN.
- SCAN outputs:
  - S=slot, Y=shadow[slot], VALID=1, BUSY=1.
- SCAN, each cycle:
  - If pre≠DIV-1: pre increments.
  - If pre=DIV-1: pre<=0, then:
    - slot<15: slot<=slot+1.
    - slot=15 and LOOP=1: shadow<=D, slot<=0, stay in SCAN. There is no gap cycle and VALID stays high.
    - slot=15 and LOOP=0: next state DONE.
- DONE: lasts one cycle with DONE=1, BUSY=1, VALID=0, S=0, Y=0. The next state is always IDLE.
- START is ignored in SCAN and DONE. It is not queued.
  - START held high through DONE is seen again in IDLE, which starts a new frame. The gap is one DONE cycle plus one IDLE cycle.
- D changes during SCAN have no effect until the next capture.
- LOOP is read only at the slot-15 boundary. Changing it mid-frame has no effect until that boundary.
- Slot order is ascending: bit D[0] goes out first and D[15] goes out last.

## Timing
- Reset: asserting RST_N low immediately forces every output to 0 (S=0, Y=0, VALID=0, BUSY=0, DONE=0). It also forces state IDLE, shadow=0, slot=0 and pre=0.
  - Reset mid-frame aborts the frame. No DONE pulse is produced.
  - After RST_N is released, the first edge can accept START.
- Latency: if START=1 is sampled at edge k, then S=0, VALID=1 and Y=D[0] (D as sampled at edge k) become valid after edge k+1.
- Each slot is held for exactly DIV cycles. S changes only on slot boundaries.
- A non-looping frame is 16·DIV cycles of VALID followed by 1 DONE cycle. Back-to-back frames repeat every 16·DIV+2 cycles.
- A looping frame runs continuously with period 16·DIV cycles. The new capture takes effect in the same cycle that slot 0 reappears.
- Wrap-around: slot never exceeds 15, and pre never reaches DIV.

## Test plan
- DIV=1, D=16'hA5C3, one START pulse:
  - VALID is high for 16 cycles.
  - S runs 0..15.
  - Y is 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1.
  - DONE pulses in cycle 17, then the block returns to IDLE with all outputs 0.
- DIV=3, D=16'h8001:
  - Each S value is held for 3 cycles.
  - Y=1 during slots 0 and 15 only.
  - VALID is high for 48 cycles, then DONE pulses once.
- DIV=1, LOOP=1, D=16'hFFFF for the first frame, then D=16'h0000 before the slot-15 boundary:
  - The second frame starts with no gap.
  - Y=1 for 16 cycles, then Y=0 for 16 cycles.
  - VALID stays high throughout and DONE never pulses.
  - Dropping LOOP to 0 ends the run with a single DONE pulse after the current frame.
- START held high continuously with DIV=1: frames start every 18 cycles, and D is recaptured at each start.
- D toggled and START re-pulsed during SCAN: there is no effect on Y, the sequence continues from the original capture, and no extra frame follows.
- RST_N pulsed low at slot 7:
  - All outputs go to 0 asynchronously, before the next CLK edge.
  - No DONE pulse is produced.
  - A START after release begins a new frame at slot 0.
